// File: rtl/rename_alloc_ctrl.sv
// Rename-stage allocation controller: counts destination writers in the
// decode group, pops the free list, maps head PRs to slots, sequences flush recovery.
module rename_alloc_ctrl #(
  parameter int RECOVER_CYCLES = 2,
  parameter int STARVE_LIMIT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_stage4,
  input  logic       stage4_pause,
  input  logic [3:0] dec_valid,
  input  logic [3:0] dec_has_rd,
  input  logic [5:0] freelist_room,
  input  logic [5:0] freePR0,
  input  logic [5:0] freePR1,
  input  logic [5:0] freePR2,
  input  logic [5:0] freePR3,
  output logic [2:0] PR_num_need,
  output logic       ren_stall,
  output logic [3:0] ren_valid,
  output logic [5:0] ren_pdst0,
  output logic [5:0] ren_pdst1,
  output logic [5:0] ren_pdst2,
  output logic [5:0] ren_pdst3,
  output logic       starve_alarm,
  output logic       recovering
);

  localparam logic       S_RUN     = 1'b0;
  localparam logic       S_RECOVER = 1'b1;
  localparam logic [3:0] REC_LOAD  = 4'(RECOVER_CYCLES - 1);
  localparam logic [8:0] ALARM_AT  = 9'(STARVE_LIMIT);

  logic       state;
  logic [3:0] rec_cnt;
  logic [7:0] starve_cnt;
  logic [7:0] starve_nxt;

  logic [3:0] wr;
  logic [2:0] k1;
  logic [2:0] k2;
  logic [2:0] k3;
  logic [2:0] need;
  logic       room_ok;
  logic       active;
  logic       fire;
  logic       starved;

  logic [3:0][5:0] free_pr;
  logic [5:0] map0;
  logic [5:0] map1;
  logic [5:0] map2;
  logic [5:0] map3;

  assign wr      = dec_valid & dec_has_rd;
  assign k1      = {2'b00, wr[0]};
  assign k2      = k1 + {2'b00, wr[1]};
  assign k3      = k2 + {2'b00, wr[2]};
  assign need    = k3 + {2'b00, wr[3]};
  assign room_ok = {3'b000, need} <= freelist_room;

  assign active  = (state == S_RUN) & (|dec_valid)
                 & ~stage4_pause & ~flush_stage4;
  assign fire    = active & room_ok;
  assign starved = active & ~room_ok;

  assign PR_num_need = fire ? need : 3'd0;
  assign ren_stall   = (|dec_valid) & ~fire;
  assign recovering  = (state == S_RECOVER);

  // Slot i takes the head entry indexed by the writers older than it.
  assign free_pr = {freePR3, freePR2, freePR1, freePR0};
  assign map0    = wr[0] ? free_pr[0]        : 6'd0;
  assign map1    = wr[1] ? free_pr[k1[1:0]] : 6'd0;
  assign map2    = wr[2] ? free_pr[k2[1:0]] : 6'd0;
  assign map3    = wr[3] ? free_pr[k3[1:0]] : 6'd0;

  always_comb begin
    starve_nxt = starve_cnt;
    if (fire || flush_stage4)
      starve_nxt = 8'd0;
    else if (starved && starve_cnt != 8'hFF)
      starve_nxt = starve_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      rec_cnt <= 4'd0;
    end else if (flush_stage4) begin
      state   <= S_RECOVER;
      rec_cnt <= REC_LOAD;
    end else if (state == S_RECOVER) begin
      if (rec_cnt == 4'd0)
        state <= S_RUN;
      else
        rec_cnt <= rec_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt   <= 8'd0;
      starve_alarm <= 1'b0;
    end else begin
      starve_cnt   <= starve_nxt;
      starve_alarm <= {1'b0, starve_nxt} >= ALARM_AT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ren_valid <= 4'd0;
      ren_pdst0 <= 6'd0;
      ren_pdst1 <= 6'd0;
      ren_pdst2 <= 6'd0;
      ren_pdst3 <= 6'd0;
    end else if (flush_stage4) begin
      ren_valid <= 4'd0;
    end else if (stage4_pause) begin
      ren_valid <= ren_valid;
    end else if (fire) begin
      ren_valid <= dec_valid;
      ren_pdst0 <= map0;
      ren_pdst1 <= map1;
      ren_pdst2 <= map2;
      ren_pdst3 <= map3;
    end else begin
      ren_valid <= 4'd0;
    end
  end

endmodule
